sram_stream_reader: RTL and testbench
=====================================

Name: sram_stream_reader

Overview:
- Read-side client for the team's 1-cycle-latency SRAM.
- Drives the SRAM read address port and collects read data. A burst is set by a start pulse, base address and length.
- Emits the words in order on a valid/ready stream with a last flag.
- Absorbs the SRAM's fixed read latency and downstream backpressure with a 3-entry output FIFO. Sustains 1 word/cycle when the sink is always ready.

Parameters:
- ADDR_WIDTH, 11, SRAM address width; must match the SRAM instance.
- DATA_WIDTH, 32, SRAM word width; must match the SRAM instance.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  1-cycle burst request; sampled only when busy=0.
- base_addr  input  ADDR_WIDTH  first word address; captured with start.
- length  input  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; captured with start.
- busy  output  1  high from the cycle after an accepted start until the final word handshakes.
- done  output  1  1-cycle pulse at burst completion.
- sram_raddr  output  ADDR_WIDTH  to SRAM raddr; driven directly from an internal register.
- sram_dout  input  DATA_WIDTH (signed)  from SRAM dout; valid the cycle after the address is presented.
- m_valid  output  1  stream word available.
- m_ready  input  1  sink accepts; handshake = m_valid & m_ready.
- m_data  output  DATA_WIDTH (signed)  stream word = FIFO head.
- m_last  output  1  marks the final word of the burst; qualified by m_valid.

Behaviour:
- Reset values: busy=0, done=0, m_valid=0, m_last=0, sram_raddr=0. FIFO count=0, inflight=0, state=IDLE.
- rst mid-burst aborts immediately. FIFO contents are discarded and no done pulse is generated. Any SRAM read in flight is ignored.
- States:
  - IDLE: on start, capture base_addr into addr_reg, length into issue_left and pop_left. If length=0 go to FIN, else go to RUN.
  - RUN: issue reads and pop words. When the final handshake occurs (pop_left goes 1->0), go to FIN.
  - FIN: done=1 for exactly this one cycle, busy=0, then go to IDLE. A start in FIN is ignored.
- start while busy is ignored. start in IDLE on the same cycle as the IDLE entry is accepted.
- Issue rule, evaluated combinationally each RUN cycle:
  - issue = (issue_left != 0) && (fifo_count + inflight < 3), using registered values with no pop lookahead.
  - On issue: addr_reg increments modulo 2^ADDR_WIDTH (wraps 2^ADDR_WIDTH-1 -> 0), issue_left decrements, and inflight is 1 in the next cycle.
- sram_raddr = addr_reg at all times. The SRAM read of addr_reg issued in cycle k appears on sram_dout in cycle k+1.
- Capture: in any cycle with inflight=1, sram_dout is pushed into the FIFO at the end of that cycle. The credit rule guarantees no overflow.
- A push and a pop in the same cycle leave fifo_count unchanged.
- FIFO: 3 entries, in-order. m_valid = (fifo_count != 0). m_data = head.
- m_data and m_last hold stable while m_valid=1 and m_ready=0.
- m_last = m_valid && (pop_left == 1).
- pop_left decrements on each handshake.
- Latency: start sampled at edge 0 -> sram_raddr=base in cycle 1 -> data pushed at end of cycle 2 -> m_valid=1 in cycle 3.
- Throughput: with m_ready held high, one word per cycle after fill. A length-N burst gives done in cycle N+3.
- Backpressure: with m_ready=0, issuing stops once count+inflight=3. Issuing resumes the cycle after a pop reduces the count.
- length = 2^ADDR_WIDTH reads every address exactly once, starting at base and wrapping.
- m_ready asserted while m_valid=0 has no effect.

Test Plan:
- Reset, idle: rst for 2 cycles, m_ready=1 -> all outputs 0, no done; sram_raddr=0.
- Basic burst: SRAM preloaded mem[i]=i*3; start, base=10, length=4, m_ready=1 -> m_valid in cycles 3..6 with data 30,33,36,39; m_last only on 39; done pulse in cycle 7; busy low afterwards.
- Backpressure: same burst with m_ready toggling 1,0,0,1,0,1,... -> data order 30,33,36,39 with no loss or duplication; sram_raddr never more than 3 words ahead of the words popped; data held stable while stalled.
- Wrap and zero length: base=2045, length=5 (ADDR_WIDTH=11) -> addresses 2045,2046,2047,0,1 in order. Then start with length=0 -> done pulse the cycle after start, m_valid stays 0.
- Reset mid-burst: length=8, assert rst after 3 handshakes -> next cycle m_valid=0, busy=0, no done. A new burst base=0, length=2 returns only mem[0], mem[1].
- Start ignored while busy: pulse start again mid-burst with different base/length -> the original burst completes unchanged, exactly one done pulse.

Source files
------------

// File: rtl/sram_stream_reader.sv
// Streams a burst of SRAM words out on valid/ready; first word is valid 3 cycles after start is sampled.
// Backpressure: reads stall once FIFO occupancy + in-flight read reach 3; m_data/m_last hold while m_ready=0.
module sram_stream_reader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [ADDR_WIDTH:0]          length,
    output logic                         busy,
    output logic                         done,
    output logic [ADDR_WIDTH-1:0]        sram_raddr,
    input  logic signed [DATA_WIDTH-1:0] sram_dout,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic                         m_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                         state;
    state_t                         state_nxt;
    logic [ADDR_WIDTH-1:0]          addr_reg;
    logic [ADDR_WIDTH:0]            issue_left;
    logic [ADDR_WIDTH:0]            pop_left;
    logic                           inflight;
    logic signed [DATA_WIDTH-1:0]   fifo_mem [0:2];
    logic [1:0]                     rd_ptr;
    logic [1:0]                     wr_ptr;
    logic [1:0]                     fifo_count;
    logic [2:0]                     credit_used;
    logic                           accept;
    logic                           issue;
    logic                           push;
    logic                           pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign sram_raddr  = addr_reg;
    assign m_valid     = (fifo_count != 2'd0);
    assign m_data      = fifo_mem[rd_ptr];
    assign m_last      = m_valid && (pop_left == CNT_ONE);
    assign push        = inflight;
    assign pop         = m_valid && m_ready;
    // Registered occupancy only: a pop this cycle frees its slot for next cycle's issue.
    assign credit_used = {1'b0, fifo_count} + {2'b00, inflight};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (length == CNT_ZERO) ? FIN : RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                issue = (issue_left != CNT_ZERO) && (credit_used < 3'd3);
                if (pop && (pop_left == CNT_ONE)) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_reg   <= '0;
            issue_left <= '0;
            pop_left   <= '0;
            inflight   <= 1'b0;
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            fifo_count <= 2'd0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;

            if (accept) begin
                addr_reg   <= base_addr;
                issue_left <= length;
                pop_left   <= length;
            end else begin
                if (issue) begin
                    addr_reg   <= addr_reg + ADDR_ONE;
                    issue_left <= issue_left - CNT_ONE;
                end
                if (pop) begin
                    pop_left <= pop_left - CNT_ONE;
                end
            end

            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sram_dout;
        end
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: SRAM model, expected-word queue model and directed scenarios.
module tb_sram_stream_reader;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int DEPTH = 2048;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [AW:0]          length;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        sram_raddr;
    logic signed [DW-1:0] sram_dout;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [DW-1:0] m_data;
    logic                 m_last;

    always #5 clk = ~clk;

    sram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .sram_raddr(sram_raddr),
        .sram_dout (sram_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    // 1-cycle-latency SRAM
    logic signed [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) sram_dout <= mem[sram_raddr];

    typedef struct {
        logic signed [DW-1:0] d;
        logic                 l;
    } word_t;

    word_t                exp_q[$];
    logic signed [DW-1:0] obs_q[$];
    word_t                w_mon;
    int                   checks = 0;
    int                   errors = 0;
    int                   done_cnt = 0;
    int                   burst_pops = 0;
    logic [AW-1:0]        cur_base = '0;
    logic [AW-1:0]        issued_w;
    logic                 prev_stall = 1'b0;
    logic signed [DW-1:0] prev_data;
    logic                 prev_last;
    int                   rdy_mode = 0;   // 0: always ready, 1: never ready, 2: pattern
    logic [5:0]           rdy_pat = 6'b101001;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Per-cycle compare against the expected-word queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (busy) begin
                issued_w = sram_raddr - cur_base;
                checks++;
                if (int'(issued_w) > burst_pops + 3) begin
                    errors++;
                    $display("FAIL credit actual=%0d expected<=%0d", issued_w, burst_pops + 3);
                end
            end
            if (!m_valid) chk("last_without_valid", m_last, 0);
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word actual=%0d expected=none", m_data);
                end else begin
                    w_mon = exp_q.pop_front();
                    chk("data", m_data, w_mon.d);
                    chk("last", m_last, w_mon.l);
                end
                obs_q.push_back(m_data);
                burst_pops++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // Sink ready driver
    initial begin
        int k;
        k = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       m_ready = 1'b0;
                2: begin
                    m_ready = rdy_pat[k % 6];
                    k++;
                end
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Call at posedge+#1; returns at posedge+#1 of the cycle after start is sampled.
    task automatic launch(input logic [AW-1:0] b, input logic [AW:0] n, input bit model);
        word_t w;
        if (model) begin
            for (int i = 0; i < int'(n); i++) begin
                w.d = mem[(int'(b) + i) % DEPTH];
                w.l = (i == int'(n) - 1);
                exp_q.push_back(w);
            end
            cur_base   = b;
            burst_pops = 0;
            obs_q.delete();
        end
        start     = 1'b1;
        base_addr = b;
        length    = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c0;
        int t;
        c0 = done_cnt;
        t  = 0;
        while (done_cnt == c0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt == c0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=timeout expected=done within %0d cycles", name, budget);
        end
        #1;
    endtask

    initial begin
        int d0;
        int t;
        for (int i = 0; i < DEPTH; i++) mem[i] = i * 3;
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;

        // Reset and idle
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_raddr", sram_raddr, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_valid", m_valid, 0);
        chk("idle_raddr", sram_raddr, 0);

        // Basic burst, latency pinned cycle by cycle
        @(posedge clk); #1;
        launch(11'd10, 12'd4, 1'b1);
        @(negedge clk);
        chk("basic_c1_raddr", sram_raddr, 10);
        chk("basic_c1_busy", busy, 1);
        chk("basic_c1_valid", m_valid, 0);
        @(negedge clk);
        chk("basic_c2_valid", m_valid, 0);
        @(negedge clk);
        chk("basic_c3_valid", m_valid, 1);
        chk("basic_c3_data", m_data, 30);
        chk("basic_c3_last", m_last, 0);
        repeat (3) @(negedge clk);
        chk("basic_c6_data", m_data, 39);
        chk("basic_c6_last", m_last, 1);
        @(negedge clk);
        chk("basic_c7_done", done, 1);
        chk("basic_c7_busy", busy, 0);
        chk("basic_c7_valid", m_valid, 0);
        @(negedge clk);
        chk("basic_c8_done", done, 0);
        chk("basic_words", obs_q.size(), 4);
        chk("basic_done_cnt", done_cnt, 1);

        // Backpressure: full stall, then toggling ready
        @(posedge clk); #1;
        rdy_mode = 1;
        m_ready  = 1'b0;
        launch(11'd10, 12'd4, 1'b1);
        repeat (8) @(negedge clk);
        chk("bp_stall_raddr", sram_raddr, 13);
        chk("bp_stall_valid", m_valid, 1);
        chk("bp_stall_data", m_data, 30);
        chk("bp_stall_busy", busy, 1);
        @(posedge clk); #1;
        rdy_mode = 2;
        wait_done("bp_done", 100);
        rdy_mode = 0;
        chk("bp_words", obs_q.size(), 4);
        chk("bp_left", exp_q.size(), 0);
        chk("bp_w3", obs_q[3], 39);

        // Address wrap
        launch(11'd2045, 12'd5, 1'b1);
        wait_done("wrap_done", 100);
        chk("wrap_words", obs_q.size(), 5);
        chk("wrap_w0", obs_q[0], 6135);
        chk("wrap_w2", obs_q[2], 6141);
        chk("wrap_w3", obs_q[3], 0);
        chk("wrap_w4", obs_q[4], 3);
        chk("wrap_raddr", sram_raddr, 2);

        // Zero length
        launch(11'd300, 12'd0, 1'b1);
        @(negedge clk);
        chk("zl_done", done, 1);
        chk("zl_busy", busy, 0);
        chk("zl_valid", m_valid, 0);
        @(negedge clk);
        chk("zl_done_off", done, 0);
        chk("zl_valid2", m_valid, 0);
        chk("zl_words", obs_q.size(), 0);

        // Reset mid-burst
        @(posedge clk); #1;
        launch(11'd20, 12'd8, 1'b1);
        t = 0;
        while (burst_pops < 3 && t < 50) begin
            @(posedge clk);
            t++;
        end
        if (burst_pops < 3) begin
            checks++;
            errors++;
            $display("FAIL rm_wait actual=%0d expected=3 handshakes", burst_pops);
        end
        #1;
        rst = 1'b1;
        d0  = done_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rm_valid", m_valid, 0);
        chk("rm_busy", busy, 0);
        chk("rm_done", done, 0);
        chk("rm_raddr", sram_raddr, 0);
        chk("rm_done_cnt", done_cnt - d0, 0);
        @(posedge clk); #1;
        launch(11'd0, 12'd2, 1'b1);
        wait_done("rm2_done", 100);
        chk("rm2_words", obs_q.size(), 2);
        chk("rm2_w0", obs_q[0], 0);
        chk("rm2_w1", obs_q[1], 3);

        // Start ignored while busy
        launch(11'd100, 12'd6, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 11'd500; length = 12'd2;
        @(posedge clk); #1;
        start = 1'b0;
        d0 = done_cnt;
        wait_done("ig_done", 100);
        chk("ig_words", obs_q.size(), 6);
        chk("ig_w5", obs_q[5], 315);
        chk("ig_left", exp_q.size(), 0);
        repeat (6) @(negedge clk);
        chk("ig_done_cnt", done_cnt - d0, 1);
        chk("ig_valid", m_valid, 0);
        chk("ig_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
